// File: rtl/spi_slave.sv
// SPI slave front end: deserialises 10-bit command frames and serialises read data.
// Ports: clk, rst (sync, active-high), SS_n, MOSI -> rx_data/rx_valid; tx_data/tx_valid -> MISO.
// Optional macro SPI_SLAVE_SVA_EN compiles in protocol assertions and state covers.
module spi_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int FW = ADDR_SIZE + 2;
  localparam int CW = $clog2(FW);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [FW-2:0]        sh_q, sh_d;
  logic [FW-1:0]        rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 flag_q, flag_d;
  logic [ADDR_SIZE-1:0] tx_sh_q, tx_sh_d;
  logic [CW-1:0]        tx_left_q, tx_left_d;
  logic                 tx_cap_q, tx_cap_d;
  logic                 miso_q, miso_d;
  logic                 last_bit;
  logic                 rx_done;

  // cnt_q counts bits 8..0; FW-1 means the frame is complete.
  assign last_bit = (cnt_q == CW'(FW - 2));
  assign rx_done  = (cnt_q == CW'(FW - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    flag_d     = flag_q;
    tx_sh_d    = tx_sh_q;
    tx_left_d  = tx_left_q;
    tx_cap_d   = tx_cap_q;
    miso_d     = miso_q;
    if (SS_n) begin
      // Abort or end of transfer: drop any partial frame or byte.
      state_d   = IDLE;
      cnt_d     = '0;
      tx_left_d = '0;
      tx_cap_d  = 1'b0;
      miso_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = CHK_CMD;
          cnt_d     = '0;
          tx_left_d = '0;
          tx_cap_d  = 1'b0;
          miso_d    = 1'b0;
        end
        CHK_CMD: begin
          sh_d = {{(FW - 2){1'b0}}, MOSI};
          if (!MOSI)
            state_d = WRITE;
          else if (flag_q)
            state_d = READ_DATA;
          else
            state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!rx_done) begin
            sh_d  = {sh_q[FW-3:0], MOSI};
            cnt_d = cnt_q + 1'b1;
            if (last_bit) begin
              rx_data_d  = {sh_q, MOSI};
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD)
                flag_d = 1'b1;
            end
          end else if (state_q == READ_DATA) begin
            if (!tx_cap_q) begin
              if (tx_valid) begin
                miso_d    = tx_data[ADDR_SIZE-1];
                tx_sh_d   = {tx_data[ADDR_SIZE-2:0], 1'b0};
                tx_left_d = CW'(ADDR_SIZE - 1);
                tx_cap_d  = 1'b1;
                flag_d    = 1'b0;
              end
            end else if (tx_left_q != '0) begin
              miso_d    = tx_sh_q[ADDR_SIZE-1];
              tx_sh_d   = {tx_sh_q[ADDR_SIZE-2:0], 1'b0};
              tx_left_d = tx_left_q - 1'b1;
            end else begin
              miso_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      flag_q     <= 1'b0;
      tx_sh_q    <= '0;
      tx_left_q  <= '0;
      tx_cap_q   <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      flag_q     <= flag_d;
      tx_sh_q    <= tx_sh_d;
      tx_left_q  <= tx_left_d;
      tx_cap_q   <= tx_cap_d;
      miso_q     <= miso_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_SVA_EN
  a_rxv_pulse: assert property (@(posedge clk) disable iff (rst)
    rx_valid_q |=> !rx_valid_q);
  a_rxv_bits: assert property (@(posedge clk) disable iff (rst)
    rx_valid_q |-> rx_done);
  a_miso_idle: assert property (@(posedge clk) disable iff (rst)
    (state_q != READ_DATA) |-> !miso_q);
  a_ss_idle: assert property (@(posedge clk) disable iff (rst)
    SS_n |=> (state_q == IDLE));
  c_idle_chk: cover property (@(posedge clk)
    state_q == IDLE ##1 state_q == CHK_CMD);
  c_chk_wr: cover property (@(posedge clk)
    state_q == CHK_CMD ##1 state_q == WRITE);
  c_chk_ra: cover property (@(posedge clk)
    state_q == CHK_CMD ##1 state_q == READ_ADD);
  c_chk_rd: cover property (@(posedge clk)
    state_q == CHK_CMD ##1 state_q == READ_DATA);
  c_chk_idle: cover property (@(posedge clk)
    state_q == CHK_CMD ##1 state_q == IDLE);
  c_wr_idle: cover property (@(posedge clk)
    state_q == WRITE ##1 state_q == IDLE);
  c_ra_idle: cover property (@(posedge clk)
    state_q == READ_ADD ##1 state_q == IDLE);
  c_rd_idle: cover property (@(posedge clk)
    state_q == READ_DATA ##1 state_q == IDLE);
`else
  // Checks compiled out.
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed vector table,
// hand-written reset sequences and randomized frames vs a frame-level model.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic       m_flag;
  logic [9:0] m_rx;

  typedef struct {
    logic [9:0] f;
    int         nbits;
    int         gap;
    int         hold;
    bit         tx_en;
    int         tx_dly;
    logic [7:0] tx_b;
    int         cut;
    logic [9:0] exp_rx;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick(input string nm, input logic ss, input logic mosi,
                      input logic tv, input logic [7:0] td,
                      input logic erv, input logic emiso);
    SS_n     = ss;
    MOSI     = mosi;
    tx_valid = tv;
    tx_data  = td;
    @(posedge clk);
    #1;
    chk({nm, "_rxv"}, {31'd0, rx_valid}, {31'd0, erv});
    chk({nm, "_rxd"}, {22'd0, rx_data}, {22'd0, m_rx});
    chk({nm, "_miso"}, {31'd0, MISO}, {31'd0, emiso});
  endtask

  // One transaction: gap, frame (possibly aborted), optional read-back.
  task automatic run_frame(input logic [9:0] f, input int nbits,
                           input int gap, input int hold, input bit tx_en,
                           input int tx_dly, input logic [7:0] tx_b,
                           input int cut, output logic [7:0] got);
    bit rd, ra, cap;
    got = 8'h00;
    for (int i = 0; i < gap; i++)
      tick("gap", 1'b1, rb(), rb(), 8'hFF, 1'b0, 1'b0);
    tick("e0", 1'b0, rb(), rb(), 8'hFF, 1'b0, 1'b0);
    rd = f[9] && m_flag;
    ra = f[9] && !m_flag;
    for (int b = 0; b < nbits; b++) begin
      if (b == 9) m_rx = f;
      tick("bit", 1'b0, f[9-b], rb(), 8'hFF, b == 9, 1'b0);
    end
    if (nbits < 10) begin
      tick("abort", 1'b1, rb(), 1'b0, 8'h00, 1'b0, 1'b0);
      return;
    end
    if (ra) m_flag = 1'b1;
    for (int i = 0; i < tx_dly; i++)
      tick("wait", 1'b0, rb(), rd ? 1'b0 : rb(), 8'($urandom),
           1'b0, 1'b0);
    cap = 1'b0;
    if (tx_en) begin
      cap = rd;
      if (cap) m_flag = 1'b0;
      tick("tx0", 1'b0, rb(), 1'b1, tx_b, 1'b0, cap & tx_b[7]);
      got[7] = MISO;
      for (int k = 1; k <= 7; k++) begin
        if (cut != 0 && k == cut) break;
        tick("txk", 1'b0, rb(), rb(), 8'($urandom), 1'b0,
             cap & tx_b[7-k]);
        got[7-k] = MISO;
      end
    end
    if (cut == 0)
      for (int i = 0; i < hold; i++)
        tick("hold", 1'b0, rb(), (rd && !tx_en) ? 1'b0 : rb(),
             8'($urandom), 1'b0, 1'b0);
    tick("end", 1'b1, rb(), rb(), 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic ss, input logic mosi);
    rst      = 1'b1;
    SS_n     = ss;
    MOSI     = mosi;
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(posedge clk);
    #1;
    m_rx   = '0;
    m_flag = 1'b0;
    chk("rst_rxv", {31'd0, rx_valid}, 32'd0);
    chk("rst_rxd", {22'd0, rx_data}, 32'd0);
    chk("rst_miso", {31'd0, MISO}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] got;
    logic [9:0] f;
    vecs[0]  = '{10'h0A5, 10, 2, 0, 0, 0, 8'h00, 0, 10'h0A5, 8'h00};
    vecs[1]  = '{10'h1C3, 10, 0, 0, 0, 0, 8'h00, 0, 10'h1C3, 8'h00};
    vecs[2]  = '{10'h203, 10, 0, 1, 0, 0, 8'h00, 0, 10'h203, 8'h00};
    vecs[3]  = '{10'h35A, 10, 0, 2, 1, 3, 8'hB6, 0, 10'h35A, 8'hB6};
    vecs[4]  = '{10'h0F0,  5, 1, 0, 0, 0, 8'h00, 0, 10'h35A, 8'h00};
    vecs[5]  = '{10'h155, 10, 0, 0, 0, 0, 8'h00, 0, 10'h155, 8'h00};
    vecs[6]  = '{10'h0AA, 10, 0, 3, 1, 1, 8'hFF, 0, 10'h0AA, 8'h00};
    vecs[7]  = '{10'h2FF, 10, 1, 0, 1, 0, 8'hFF, 0, 10'h2FF, 8'h00};
    vecs[8]  = '{10'h2C1, 10, 0, 1, 1, 0, 8'h5A, 0, 10'h2C1, 8'h5A};
    vecs[9]  = '{10'h210, 10, 0, 0, 0, 0, 8'h00, 0, 10'h210, 8'h00};
    vecs[10] = '{10'h3AB,  7, 0, 0, 0, 0, 8'h00, 0, 10'h210, 8'h00};
    vecs[11] = '{10'h3CD, 10, 0, 0, 1, 5, 8'h81, 4, 10'h3CD, 8'h80};
    vecs[12] = '{10'h001, 10, 0, 4, 0, 0, 8'h00, 0, 10'h001, 8'h00};
    vecs[13] = '{10'h3FF, 10, 0, 0, 1, 2, 8'hC3, 0, 10'h3FF, 8'h00};

    rst      = 1'b1;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    m_flag   = 1'b0;
    m_rx     = '0;
    repeat (2) @(posedge clk);
    do_reset(1'b1, 1'b0);

    for (int i = 0; i < 14; i++) begin
      run_frame(vecs[i].f, vecs[i].nbits, vecs[i].gap, vecs[i].hold,
                vecs[i].tx_en, vecs[i].tx_dly, vecs[i].tx_b,
                vecs[i].cut, got);
      chk($sformatf("vec%0d_rx", i), {22'd0, rx_data},
          {22'd0, vecs[i].exp_rx});
      chk($sformatf("vec%0d_byte", i), {24'd0, got},
          {24'd0, vecs[i].exp_byte});
    end

    // Clear the flag, then reset six bits into a read-address frame.
    run_frame(10'h300, 10, 1, 0, 1, 0, 8'h3C, 0, got);
    chk("pre_rst_byte", {24'd0, got}, 32'h3C);
    f = 10'h2AA;
    tick("r_e0", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int b = 0; b < 5; b++)
      tick("r_bit", 1'b0, f[9-b], 1'b0, 8'h00, 1'b0, 1'b0);
    do_reset(1'b0, f[4]);
    run_frame(10'h3C3, 10, 1, 0, 1, 1, 8'hA5, 0, got);
    chk("post_rst_route", {24'd0, got}, 32'h00);
    run_frame(10'h3C3, 10, 0, 1, 1, 0, 8'h96, 0, got);
    chk("post_rst_rd", {24'd0, got}, 32'h96);

    // Reset while idle must clear a set read-address flag.
    run_frame(10'h211, 10, 0, 0, 0, 0, 8'h00, 0, got);
    do_reset(1'b1, 1'b0);
    run_frame(10'h311, 10, 1, 0, 1, 0, 8'h77, 0, got);
    chk("flag_rst_ra", {24'd0, got}, 32'h00);
    chk("flag_rst_rx", {22'd0, rx_data}, 32'h311);
    run_frame(10'h311, 10, 0, 0, 1, 0, 8'h77, 0, got);
    chk("flag_rst_rd", {24'd0, got}, 32'h77);

    for (int n = 0; n < 150; n++) begin
      int nb, ct;
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 10;
      ct = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(10'($urandom), nb, $urandom_range(0, 2),
                $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                $urandom_range(0, 4), 8'($urandom), ct, got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
